// File: rtl/adv7185_init_pkg.sv
// Shared definitions for the ADV7185 power-up sequencer.
// Contains the state encoding, the decoder sub-address names and the default init table.
package adv7185_init_pkg;

  typedef enum logic [3:0] {
    S_PWRUP     = 4'd0,
    S_WAIT_IDLE = 4'd1,
    S_DEV       = 4'd2,
    S_SUB       = 4'd3,
    S_DAT       = 4'd4,
    S_STOP      = 4'd5,
    S_GAP       = 4'd6,
    S_DONE      = 4'd7,
    S_ERR       = 4'd8
  } state_t;

  localparam logic [7:0] INPUT_CTRL      = 8'h00;
  localparam logic [7:0] VIDEO_SEL       = 8'h01;
  localparam logic [7:0] OUTPUT_CTRL     = 8'h03;
  localparam logic [7:0] EXT_OUTPUT_CTRL = 8'h04;
  localparam logic [7:0] AUTODETECT_EN   = 8'h07;
  localparam logic [7:0] CONTRAST        = 8'h08;
  localparam logic [7:0] BRIGHTNESS      = 8'h0A;
  localparam logic [7:0] HUE             = 8'h0B;
  localparam logic [7:0] DEFAULT_Y       = 8'h0C;
  localparam logic [7:0] DEFAULT_C       = 8'h0D;
  localparam logic [7:0] POWER_MGMT      = 8'h0F;
  localparam logic [7:0] ANALOG_CTRL     = 8'h13;
  localparam logic [7:0] DIGITAL_CLAMP   = 8'h15;
  localparam logic [7:0] SHAPING_FILTER  = 8'h17;
  localparam logic [7:0] ADC_CTRL        = 8'h3A;
  localparam logic [7:0] PIXEL_DELAY     = 8'h50;

  // Returns {subaddr, data}; the INPUT_CTRL low nibble is replaced by the source select.
  function automatic logic [15:0] init_entry(input logic [7:0] idx);
    logic [15:0] e;
    case (idx)
      8'd0:    e = {INPUT_CTRL,      8'h04};
      8'd1:    e = {VIDEO_SEL,       8'hC8};
      8'd2:    e = {OUTPUT_CTRL,     8'h0C};
      8'd3:    e = {EXT_OUTPUT_CTRL, 8'h77};
      8'd4:    e = {AUTODETECT_EN,   8'h7F};
      8'd5:    e = {CONTRAST,        8'h80};
      8'd6:    e = {BRIGHTNESS,      8'h00};
      8'd7:    e = {HUE,             8'h00};
      8'd8:    e = {DEFAULT_Y,       8'h36};
      8'd9:    e = {DEFAULT_C,       8'h7C};
      8'd10:   e = {POWER_MGMT,      8'h00};
      8'd11:   e = {ANALOG_CTRL,     8'h45};
      8'd12:   e = {DIGITAL_CLAMP,   8'h00};
      8'd13:   e = {SHAPING_FILTER,  8'h41};
      8'd14:   e = {ADC_CTRL,        8'h16};
      8'd15:   e = {PIXEL_DELAY,     8'h04};
      default: e = 16'h0000;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/adv7185_init_rom.sv
// Combinational init-table lookup: entry index -> {sub-address, data}.
module adv7185_init_rom
  import adv7185_init_pkg::*;
(
  input  logic [7:0] index,
  output logic [7:0] subaddr,
  output logic [7:0] data
);

  always_comb begin
    {subaddr, data} = init_entry(index);
  end

endmodule

// File: rtl/adv7185_init_seq.sv
// Walks the ADV7185 init table, sending each entry as a DEV/SUB/DATA write through the I2C byte sender.
// Define ADV_INIT_TIMEOUT_EN to add a watchdog that aborts into an error state.
module adv7185_init_seq
  import adv7185_init_pkg::*;
#(
  parameter logic [7:0]  DEV_ADDR     = 8'h8A,
  parameter int          N_REGS       = 16,
  parameter logic [19:0] STARTUP_WAIT = 20'd50000,
  parameter logic [7:0]  GAP_CYCLES   = 8'd32,
  parameter logic [15:0] TIMEOUT      = 16'd4096
) (
  input  logic       clock4x,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] source_sel,
  input  logic       i2c_idle,
  input  logic       i2c_ack,
  output logic       i2c_load,
  output logic [7:0] i2c_data,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] reg_index
);

  // Handshake: i2c_load is the valid, i2c_ack the one-cycle ready/accept; i2c_data is held
  // stable while i2c_load=1 and changes only the cycle after an accepted byte.
  localparam logic [7:0] LAST_IDX = 8'(N_REGS - 1);

  state_t      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [7:0]  idx_q, idx_d;
  logic [3:0]  src_q, src_d;
  logic        seen_q, seen_d;
  logic        load_q, load_d;
  logic [7:0]  data_q, data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [7:0]  rom_sub, rom_dat, pay_dat;
  logic        ack_v;

  adv7185_init_rom u_rom (
    .index   (idx_q),
    .subaddr (rom_sub),
    .data    (rom_dat)
  );

  assign pay_dat = (rom_sub == INPUT_CTRL) ? {rom_dat[7:4], src_q} : rom_dat;
  assign ack_v   = i2c_ack & load_q;

`ifdef ADV_INIT_TIMEOUT_EN
  logic [15:0] wd_q, wd_d;
  logic        err_q, err_d;
  logic        wd_active;

  assign wd_active = (state_q == S_DEV) || (state_q == S_SUB) || (state_q == S_DAT) ||
                     (state_q == S_STOP) || (state_q == S_WAIT_IDLE);
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    src_d   = src_q;
    seen_d  = seen_q;
    load_d  = load_q;
    data_d  = data_q;
    busy_d  = busy_q;
    done_d  = done_q;
`ifdef ADV_INIT_TIMEOUT_EN
    err_d   = err_q;
`endif
    case (state_q)
      S_PWRUP: begin
        if ((cnt_q + 20'd1) >= STARTUP_WAIT) begin
          cnt_d   = 20'd0;
          state_d = S_WAIT_IDLE;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      S_WAIT_IDLE: begin
        if (i2c_idle) begin
          load_d  = 1'b1;
          data_d  = DEV_ADDR;
          seen_d  = 1'b0;
          state_d = S_DEV;
        end
      end
      S_DEV: begin
        if (ack_v) begin
          data_d  = rom_sub;
          seen_d  = ~i2c_idle;
          state_d = S_SUB;
        end
      end
      S_SUB: begin
        seen_d = seen_q | ~i2c_idle;
        if (ack_v) begin
          data_d  = pay_dat;
          state_d = S_DAT;
        end
      end
      S_DAT: begin
        seen_d = seen_q | ~i2c_idle;
        if (ack_v) begin
          load_d  = 1'b0;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        // The sender's idle flag can still read 1 right after the last ack; only a 0->1 counts.
        seen_d = seen_q | ~i2c_idle;
        if (seen_q && i2c_idle) begin
          if (idx_q == LAST_IDX) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 8'd1;
            cnt_d   = 20'd0;
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        if ((cnt_q + 20'd1) >= {12'd0, GAP_CYCLES}) begin
          cnt_d   = 20'd0;
          state_d = S_WAIT_IDLE;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      S_DONE: begin
        if (start) begin
          done_d  = 1'b0;
          busy_d  = 1'b1;
          idx_d   = 8'd0;
          src_d   = source_sel;
          state_d = S_WAIT_IDLE;
        end
      end
`ifdef ADV_INIT_TIMEOUT_EN
      S_ERR: begin
        if (start) begin
          err_d   = 1'b0;
          busy_d  = 1'b1;
          idx_d   = 8'd0;
          src_d   = source_sel;
          state_d = S_WAIT_IDLE;
        end
      end
`endif
      default: ;
    endcase
`ifdef ADV_INIT_TIMEOUT_EN
    // Progress in this cycle wins over an expiring watchdog.
    if (wd_active && (state_d == state_q) && (wd_q == TIMEOUT - 16'd1)) begin
      load_d  = 1'b0;
      err_d   = 1'b1;
      busy_d  = 1'b0;
      state_d = S_ERR;
    end
    if (state_d != state_q) begin
      wd_d = 16'd0;
    end else if (wd_active) begin
      wd_d = wd_q + 16'd1;
    end else begin
      wd_d = wd_q;
    end
`endif
  end

  always_ff @(posedge clock4x) begin
    if (reset) begin
      state_q <= S_PWRUP;
      cnt_q   <= 20'd0;
      idx_q   <= 8'd0;
      src_q   <= 4'd0;
      seen_q  <= 1'b0;
      load_q  <= 1'b0;
      data_q  <= 8'd0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      src_q   <= src_d;
      seen_q  <= seen_d;
      load_q  <= load_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef ADV_INIT_TIMEOUT_EN
  always_ff @(posedge clock4x) begin
    if (reset) begin
      wd_q  <= 16'd0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign error = err_q;
`else
  assign error = 1'b0;
`endif

  assign i2c_load  = load_q;
  assign i2c_data  = data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign reg_index = idx_q;

endmodule

// File: tb/tb_adv7185_init_seq.sv
// Bench for adv7185_init_seq: behavioural I2C byte sender plus a byte-stream scoreboard.
`timescale 1ns/1ps
module tb_adv7185_init_seq;

  localparam int         N_REGS   = 3;
  localparam int         STARTUP  = 100;
  localparam int         GAP      = 32;
  localparam int         TMO      = 50;
  localparam int         BYTE_CYC = 40;
  localparam logic [7:0] DEV      = 8'h8A;

  logic       clock4x = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] source_sel = 4'd0;
  logic       i2c_idle = 1'b1;
  logic       i2c_ack = 1'b0;
  logic       i2c_load;
  logic [7:0] i2c_data;
  logic       busy, done, error;
  logic [7:0] reg_index;

  adv7185_init_seq #(
    .DEV_ADDR     (DEV),
    .N_REGS       (N_REGS),
    .STARTUP_WAIT (20'd100),
    .GAP_CYCLES   (8'd32),
    .TIMEOUT      (16'd50)
  ) dut (
    .clock4x    (clock4x),
    .reset      (reset),
    .start      (start),
    .source_sel (source_sel),
    .i2c_idle   (i2c_idle),
    .i2c_ack    (i2c_ack),
    .i2c_load   (i2c_load),
    .i2c_data   (i2c_data),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .reg_index  (reg_index)
  );

  // clock/reset block
  always #5 clock4x = ~clock4x;

  int cyc = 0;
  always @(posedge clock4x) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL global_time_limit: simulation did not finish, required finish before 900us");
    $fatal(1, "time limit");
  end

  // reference table: first three decoder entries
  logic [7:0] ref_sub [N_REGS] = '{8'h00, 8'h01, 8'h03};
  logic [7:0] ref_dat [N_REGS] = '{8'h04, 8'hC8, 8'h0C};

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic push_run(input logic [3:0] src);
    for (int i = 0; i < N_REGS; i++) begin
      exp_q.push_back(DEV);
      exp_q.push_back(ref_sub[i]);
      exp_q.push_back((ref_sub[i] == 8'h00) ? {ref_dat[i][7:4], src} : ref_dat[i]);
    end
  endtask

  // sender model state
  bit never_ack   = 1'b0;
  bit delay_mode  = 1'b0;
  bit first_txn   = 1'b1;
  bit load_in_stop;
  int m_phase     = 0;
  int m_cnt       = 0;
  int byte_in_txn = 0;
  int bytes_run   = 0;
  int idle_rise   = 0;

  task automatic take_byte();
    bytes_run++;
    byte_in_txn++;
    if (exp_q.size() == 0) check("scoreboard_has_entry", 32'd0, 32'd1);
    else check("byte", i2c_data, exp_q.pop_front());
    i2c_ack = 1'b1;
  endtask

  // Behavioural sender: ack one cycle after load, idle low 40 cycles per byte, then a stop.
  initial begin
    forever begin
      @(posedge clock4x);
      #1;
      i2c_ack = 1'b0;
      if (reset) begin
        m_phase     = 0;
        byte_in_txn = 0;
        i2c_idle    = 1'b1;
      end else begin
        case (m_phase)
          0: if (i2c_load && !never_ack) begin
               if (!first_txn) check("gap_after_idle", ((cyc - idle_rise) >= GAP), 1'b1);
               first_txn = 1'b0;
               take_byte();
               m_phase = 1;
             end
          1: begin
               i2c_idle = 1'b0;
               check("load_after_ack", i2c_load, (byte_in_txn < 3));
               if (byte_in_txn < 3 && exp_q.size() > 0)
                 check("next_byte_in_1cyc", i2c_data, exp_q[0]);
               m_cnt   = BYTE_CYC - 1;
               m_phase = 2;
             end
          2: begin
               m_cnt--;
               if (m_cnt == 0) begin
                 check("load_at_byte_end", i2c_load, (byte_in_txn < 3));
                 if (i2c_load && byte_in_txn < 3) begin
                   take_byte();
                   m_phase = 1;
                 end else begin
                   m_cnt        = delay_mode ? 500 : int'($urandom_range(2, 6));
                   load_in_stop = 1'b0;
                   m_phase      = 3;
                 end
               end
             end
          default: begin
               if (i2c_load) load_in_stop = 1'b1;
               m_cnt--;
               if (m_cnt == 0) begin
                 check("no_load_during_stop", load_in_stop, 1'b0);
                 i2c_idle    = 1'b1;
                 idle_rise   = cyc;
                 byte_in_txn = 0;
                 m_phase     = 0;
               end
             end
        endcase
      end
    end
  end

  // driver tasks
  task automatic check_reset_state();
    check("rst_load", i2c_load, 1'b0);
    check("rst_data", i2c_data, 8'h00);
    check("rst_busy", busy, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_reg_index", reg_index, 8'h00);
  endtask

  task automatic startup_window();
    bit seen;
    seen = 1'b0;
    repeat (STARTUP) begin
      @(negedge clock4x);
      if (i2c_load) seen = 1'b1;
    end
    check("no_load_in_startup", seen, 1'b0);
    check("busy_in_startup", busy, 1'b1);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 6000) begin
      @(negedge clock4x);
      n++;
    end
    check("done_within_budget", done, 1'b1);
    check("busy_low_at_done", busy, 1'b0);
    check("reg_index_last", reg_index, N_REGS - 1);
    check("bytes_per_run", bytes_run, 3 * N_REGS);
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  task automatic pulse_start(input logic [3:0] src);
    @(negedge clock4x);
    start      = 1'b1;
    source_sel = src;
    @(negedge clock4x);
    start = 1'b0;
  endtask

  task automatic run_start(input logic [3:0] src, input bit extra);
    bytes_run = 0;
    first_txn = 1'b1;
    push_run(src);
    pulse_start(src);
    check("busy_after_start", busy, 1'b1);
    check("done_clear_after_start", done, 1'b0);
    if (extra) begin
      repeat ($urandom_range(5, 200)) @(negedge clock4x);
      pulse_start(~src);
    end
  endtask

  initial begin
    logic [3:0] src;
    int n;
    reset = 1'b1;
    repeat (3) @(negedge clock4x);
    check_reset_state();
    bytes_run = 0;
    first_txn = 1'b1;
    push_run(4'd0);
    reset = 1'b0;
    startup_window();
    wait_done();

    // source select patch, second start while busy ignored
    run_start(4'h5, 1'b1);
    wait_done();

    repeat (2) begin
      src = 4'($urandom_range(0, 15));
      run_start(src, 1'($urandom_range(0, 1)));
      wait_done();
    end

`ifndef ADV_INIT_TIMEOUT_EN
    // sender holds idle low 500 cycles after each stop
    delay_mode = 1'b1;
    run_start(4'($urandom_range(0, 15)), 1'b0);
    wait_done();
    delay_mode = 1'b0;
`endif

    // reset while the sub-address byte is loaded
    run_start(4'($urandom_range(0, 15)), 1'b0);
    n = 0;
    while (!(m_phase == 2 && byte_in_txn == 1) && n < 2000) begin
      @(negedge clock4x);
      n++;
    end
    check("reached_sub_byte", (m_phase == 2 && byte_in_txn == 1), 1'b1);
    reset = 1'b1;
    @(negedge clock4x);
    check("midrst_load", i2c_load, 1'b0);
    check("midrst_busy", busy, 1'b1);
    check("midrst_done", done, 1'b0);
    check("midrst_reg_index", reg_index, 8'h00);
    exp_q.delete();
    bytes_run = 0;
    first_txn = 1'b1;
    push_run(4'd0);
    reset = 1'b0;
    startup_window();
    wait_done();

`ifdef ADV_INIT_TIMEOUT_EN
    begin
      bit held;
      never_ack = 1'b1;
      first_txn = 1'b1;
      pulse_start(4'($urandom_range(0, 15)));
      n = 0;
      while (!i2c_load && n < 200) begin
        @(negedge clock4x);
        n++;
      end
      check("load_before_timeout", i2c_load, 1'b1);
      held = 1'b1;
      repeat (TMO - 1) begin
        @(negedge clock4x);
        if (!i2c_load || error) held = 1'b0;
      end
      check("load_held_until_timeout", held, 1'b1);
      @(negedge clock4x);
      check("timeout_error", error, 1'b1);
      check("timeout_load_low", i2c_load, 1'b0);
      check("timeout_busy_low", busy, 1'b0);
      never_ack = 1'b0;
      src = 4'($urandom_range(0, 15));
      run_start(src, 1'b0);
      check("error_cleared_by_start", error, 1'b0);
      wait_done();
    end
`else
    check("error_tied_low", error, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
